// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry and miss-service types.
// Shared by the cache and its line fill unit.
package cache_pkg;

  localparam int LINE_W = 1024;
  localparam int MEM_W  = 32;
  localparam int BEATS  = LINE_W / MEM_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } fill_state_e;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/line_beat_mux.sv
// line_beat_mux: picks one memory beat out of a cache line,
// and decodes the same beat index into a per-beat write enable.
module line_beat_mux #(
  parameter int LINE_W = 1024,
  parameter int MEM_W  = 32,
  localparam int BEATS = LINE_W / MEM_W,
  localparam int SEL_W = $clog2(BEATS)
) (
  input  logic [LINE_W-1:0] i_line,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_wr,
  output logic [MEM_W-1:0]  o_word,
  output logic [BEATS-1:0]  o_we
);

  logic [BEATS-1:0][MEM_W-1:0] w_beats;

  assign w_beats = i_line;

  // beat select for outgoing write data
  always_comb begin
    o_word = w_beats[i_sel];
  end

  // one-hot write enable for the selected beat
  always_comb begin
    o_we        = '0;
    o_we[i_sel] = i_wr;
  end

endmodule

// File: rtl/cache_line_fill_unit.sv
// cache_line_fill_unit: services a cache miss by writing back
// an optional dirty line, then fetching the new line beat by beat.
module cache_line_fill_unit
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int MEM_W  = cache_pkg::MEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              busy,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ack
);

  localparam int BEATS = LINE_W / MEM_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int BW    = $clog2(BEATS);

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(MEM_W / 8);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  fill_state_e r_state;
  logic [BW-1:0] r_beat;
  logic [ADDR_W-1:0] r_fill_base;
  logic [LINE_W-1:0] r_wb_line;
  logic r_busy;
  logic r_fill_valid;
  logic r_mem_req;
  logic r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [MEM_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_fill_line;

  logic w_ack;
  logic [BW-1:0] w_beat_nxt;
  logic [BW-1:0] w_sel;
  logic w_fill_wr;
  logic [MEM_W-1:0] w_word;
  logic [BEATS-1:0] w_we;
  logic [ADDR_W-1:0] w_miss_base;
  logic [ADDR_W-1:0] w_wb_base;

  assign w_ack       = mem_ack & r_mem_req;
  assign w_beat_nxt  = r_beat + BW'(1);
  assign w_sel       = r_mem_we ? w_beat_nxt : r_beat;
  assign w_fill_wr   = w_ack & (r_state == FILL);
  assign w_miss_base = miss_addr & ~OFF_MASK;
  assign w_wb_base   = wb_addr & ~OFF_MASK;

  line_beat_mux #(
    .LINE_W (LINE_W),
    .MEM_W  (MEM_W)
  ) u_mux (
    .i_line (r_wb_line),
    .i_sel  (w_sel),
    .i_wr   (w_fill_wr),
    .o_word (w_word),
    .o_we   (w_we)
  );

  // miss-service sequencer with registered memory request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_fill_base  <= '0;
      r_wb_line    <= '0;
      r_busy       <= 1'b0;
      r_fill_valid <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (miss_req) begin
            r_fill_base <= w_miss_base;
            r_wb_line   <= wb_line;
            r_beat      <= '0;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            if (wb_req) begin
              r_state     <= WB;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_wb_base;
              r_mem_wdata <= wb_line[MEM_W-1:0];
            end else begin
              r_state    <= FILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_miss_base;
            end
          end
        end
        WB: begin
          if (w_ack) begin
            r_beat <= w_beat_nxt;
            if (r_beat == LAST) begin
              r_state    <= FILL;
              r_mem_req  <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_fill_base;
            end else begin
              r_mem_addr  <= r_mem_addr + STEP;
              r_mem_wdata <= w_word;
            end
          end
        end
        FILL: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (w_ack) begin
            r_beat <= w_beat_nxt;
            if (r_beat == LAST) begin
              r_state      <= DONE;
              r_mem_req    <= 1'b0;
              r_fill_valid <= 1'b1;
            end else begin
              r_mem_addr <= r_mem_addr + STEP;
            end
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_fill_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // assemble returning read beats into the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_line <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (w_we[k]) begin
          r_fill_line[k*MEM_W +: MEM_W] <= mem_rdata;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign fill_valid = r_fill_valid;
  assign fill_line  = r_fill_line;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
